register_sipo: RTL and testbench

//   Serial-in / parallel-out capture register, the receiving end of the parallel-load shift-left path.
//   - Collects n bits presented MSB-first on sin, one per qualified cycle.
//   - Presents the assembled word on pout with a valid/ack handshake toward the consuming datapath.
//   - Sits between a serial bit source (e.g. the left-shifting parallel-load register's MSB) and a parallel consumer.

---
 rtl/register_sipo_pkg.sv | 17 +
 rtl/register_sipo_bit_counter.sv | 39 +++
 rtl/register_sipo.sv | 134 +++++++++++++
 tb/tb_register_sipo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/register_sipo_pkg.sv
// Shared definitions for the serial-in / parallel-out capture register:
// FSM state encodings and the bit-counter width helper.
package register_sipo_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_SHIFT = 2'd1;
    localparam state_t S_PAR   = 2'd2;
    localparam state_t S_FULL  = 2'd3;

    // Counter must hold 0..n, so it needs clog2(n+1) bits.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : register_sipo_pkg

// File: rtl/register_sipo_bit_counter.sv
// Accepted-bit counter for register_sipo: synchronous clear/increment with a
// terminal-count flag that marks the last data bit of the word.
module bit_counter
    import register_sipo_pkg::*;
#(
    parameter int n = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = cnt_w(n);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CW'(n - 1));

endmodule : bit_counter

// File: rtl/register_sipo.sv
// Serial-in / parallel-out capture register with valid/ack handshake.
// Optional even-parity check is built when REGISTER_SIPO_PARITY_EN is defined.
module register_sipo
    import register_sipo_pkg::*;
#(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sen,
    input  logic         sin,
    input  logic         ack,
    output logic [n-1:0] pout,
    output logic         valid,
    output logic         busy,
    output logic         perr
);

`ifdef REGISTER_SIPO_PARITY_EN
    localparam state_t S_AFTER_LAST = S_PAR;
`else
    localparam state_t S_AFTER_LAST = S_FULL;
`endif

    state_t       state_q;
    state_t       state_d;
    logic [n-1:0] pout_q;
    logic [n-1:0] pout_d;
    logic         perr_q;
    logic         perr_d;
    logic         cnt_clr;
    logic         cnt_inc;
    logic         cnt_tc;

    bit_counter #(
        .n (n)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .tc  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        pout_d  = pout_q;
        perr_d  = perr_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pout_d  = '0;
                    perr_d  = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                // start outranks sen: the bit offered alongside a restart is dropped.
                if (start) begin
                    pout_d  = '0;
                    perr_d  = 1'b0;
                    cnt_clr = 1'b1;
                end else if (sen) begin
                    pout_d = {pout_q[n-2:0], sin};
                    if (cnt_tc) begin
                        state_d = S_AFTER_LAST;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

`ifdef REGISTER_SIPO_PARITY_EN
            S_PAR: begin
                if (start) begin
                    pout_d  = '0;
                    perr_d  = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = S_SHIFT;
                end else if (sen) begin
                    perr_d  = ^{pout_q, sin};
                    state_d = S_FULL;
                end
            end
`endif

            S_FULL: begin
                // Word stays put until the consumer acks; a lone start is ignored.
                if (ack) begin
                    if (start) begin
                        pout_d  = '0;
                        perr_d  = 1'b0;
                        cnt_clr = 1'b1;
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pout_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pout_q  <= pout_d;
            perr_q  <= perr_d;
        end
    end

    assign pout  = pout_q;
    assign valid = (state_q == S_FULL);
    assign busy  = (state_q == S_SHIFT) || (state_q == S_PAR);
`ifdef REGISTER_SIPO_PARITY_EN
    assign perr  = perr_q;
`else
    assign perr  = 1'b0;
`endif

endmodule : register_sipo

// File: tb/tb_register_sipo.sv
// Self-checking bench for register_sipo (n=16): directed scenarios followed by
// random traffic, every cycle compared against a word-level reference model.
module tb_register_sipo;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sen = 1'b0;
    logic         sin = 1'b0;
    logic         ack = 1'b0;
    logic [N-1:0] pout;
    logic         valid;
    logic         busy;
    logic         perr;

    int n_checks = 0;
    int n_passed = 0;

    // Reference model: phase of the transfer, the word as an integer, and
    // how many data bits have been taken so far.
    localparam int P_IDLE = 0, P_COLLECT = 1, P_PARITY = 2, P_FULL = 3;
    int m_phase = P_IDLE;
    int m_word  = 0;
    int m_nbits = 0;
    int m_perr  = 0;

    register_sipo #(.n(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sen   (sen),
        .sin   (sin),
        .ack   (ack),
        .pout  (pout),
        .valid (valid),
        .busy  (busy),
        .perr  (perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_begin_word();
        m_word  = 0;
        m_nbits = 0;
        m_perr  = 0;
        m_phase = P_COLLECT;
    endtask

    task automatic model_update();
        if (rst) begin
            m_phase = P_IDLE;
            m_word  = 0;
            m_nbits = 0;
            m_perr  = 0;
        end else begin
            case (m_phase)
                P_IDLE:    if (start) model_begin_word();
                P_COLLECT: begin
                    if (start) model_begin_word();
                    else if (sen) begin
                        m_word  = (m_word * 2 + int'(sin)) % 65536;
                        m_nbits = m_nbits + 1;
`ifdef REGISTER_SIPO_PARITY_EN
                        if (m_nbits == N) m_phase = P_PARITY;
`else
                        if (m_nbits == N) m_phase = P_FULL;
`endif
                    end
                end
                P_PARITY: begin
                    if (start) model_begin_word();
                    else if (sen) begin
                        m_perr  = ($countones(m_word) + int'(sin)) % 2;
                        m_phase = P_FULL;
                    end
                end
                default: begin
                    if (ack && start) model_begin_word();
                    else if (ack) m_phase = P_IDLE;
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        chk("pout", 32'(pout), 32'(m_word));
        chk("valid", 32'(valid), 32'(m_phase == P_FULL));
        chk("busy", 32'(busy), 32'(m_phase == P_COLLECT || m_phase == P_PARITY));
`ifdef REGISTER_SIPO_PARITY_EN
        if (m_phase == P_FULL) chk("perr", 32'(perr), 32'(m_perr));
`else
        chk("perr", 32'(perr), 32'd0);
`endif
    endtask

    task automatic step(input logic r, input logic st, input logic se,
                        input logic si, input logic ak);
        rst = r; start = st; sen = se; sin = si; ack = ak;
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic send_word(input logic [N-1:0] w, input bit gaps);
        for (int i = N - 1; i >= 0; i--) begin
            if (gaps) step(1'b0, 1'b0, 1'b0, 1'($urandom), 1'b0);
            step(1'b0, 1'b0, 1'b1, w[i], 1'b0);
        end
    endtask

    // Finishes a word: supplies the even-parity bit when the parity stage exists.
    task automatic close_word(input logic [N-1:0] w);
`ifdef REGISTER_SIPO_PARITY_EN
        step(1'b0, 1'b0, 1'b1, ^w, 1'b0);
`else
        chk("close_pout", 32'(pout), 32'(w));
`endif
    endtask

    initial begin
        // 1: reset, then a plain word
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_pout", 32'(pout), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_perr", 32'(perr), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_busy", 32'(busy), 32'd1);
        send_word(16'hA5C3, 1'b0);
        close_word(16'hA5C3);
        chk("t1_pout", 32'(pout), 32'hA5C3);
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_busy_done", 32'(busy), 32'd0);

        // 2: same word with idle gaps between bits
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_word(16'hA5C3, 1'b1);
        close_word(16'hA5C3);
        chk("t2_valid", 32'(valid), 32'd1);

        // 3: FULL holds against sen/sin/start while ack is low
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            chk("t3_hold_pout", 32'(pout), 32'hA5C3);
            chk("t3_hold_valid", 32'(valid), 32'd1);
        end

        // 4: ack + start goes straight into the next word
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_valid", 32'(valid), 32'd0);
        send_word(16'h0001, 1'b0);
        close_word(16'h0001);
        chk("t4_pout", 32'(pout), 32'h0001);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_idle_valid", 32'(valid), 32'd0);

        // 5: reset mid-word, IDLE ignores sen, then an all-ones word
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_rst_pout", 32'(pout), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'($urandom));
        chk("t5_idle_pout", 32'(pout), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_word(16'hFFFF, 1'b0);
        close_word(16'hFFFF);
        chk("t5_pout", 32'(pout), 32'hFFFF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef REGISTER_SIPO_PARITY_EN
        // 6: explicit good and bad parity on 16'hA5C3
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_word(16'hA5C3, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_perr_good", 32'(perr), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send_word(16'hA5C3, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t6_perr_bad", 32'(perr), 32'd1);
        chk("t6_pout", 32'(pout), 32'hA5C3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 9) < 7),
                 1'($urandom),
                 1'($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule : tb_register_sipo
